// File: rtl/dp_mem_burst_master_pkg.sv
// Shared definitions for the dp_mem burst initiator: default widths, FSM states
// and a small state classification helper.
package dp_mem_burst_master_pkg;

    localparam int unsigned AW_DEF     = 10;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned LW_DEF     = AW_DEF + 1;
    localparam int unsigned RDEPTH_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_WRITE) || (s == ST_READ) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/dp_mem_burst_master_if.sv
// Host command/data channels plus the dp_mem port, bundled for the burst master.
// master: the burst master's view; slave: the host/memory side.
interface dp_mem_burst_master_if
    import dp_mem_burst_master_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned LW = LW_DEF
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  mem_rdata,
        output cmd_ready, wd_ready,
        output rd_valid, rd_data, rd_last,
        output busy, done,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output rd_ready,
        output mem_rdata,
        input  cmd_ready, wd_ready,
        input  rd_valid, rd_data, rd_last,
        input  busy, done,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dp_mem_burst_master_rd_fifo.sv
// Small synchronous FIFO holding read words with a per-entry end-of-burst flag.
// Head is visible combinationally; push and pop may happen in the same cycle.
module dp_mem_burst_master_rd_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       push_last,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DW-1:0]              head_data,
    output logic                       head_last
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr         <= ptr_inc(wr_ptr);
                last_q[wr_ptr] <= push_last;
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/dp_mem_burst_master.sv
// Burst initiator for a dp_mem port: streams host write data into memory, or
// streams memory reads back to the host through a credit-limited FIFO.
module dp_mem_burst_master
    import dp_mem_burst_master_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned LW     = LW_DEF,
    parameter int unsigned RDEPTH = RDEPTH_DEF
) (
    input logic                   clk,
    input logic                   reset,
    dp_mem_burst_master_if.master bus
);
    localparam int unsigned CW = $clog2(RDEPTH + 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic          inflight_last;
    logic          wr_beat;
    logic          rd_issue;
    logic          pop;
    logic          rd_avail;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic [DW-1:0] head_data;
    logic          head_last;

    assign rd_avail = (fifo_count != '0);
    assign pop      = rd_avail && bus.rd_ready;

    // A word leaving the FIFO this cycle frees its slot for this cycle's issue,
    // which is what sustains one word per cycle with only two entries.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_beat    = 1'b0;
        rd_issue   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        state_next = ST_DONE;
                    end else if (bus.cmd_write) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                wr_beat = bus.wd_valid;
                if (wr_beat && (remaining == LW'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_READ: begin
                rd_issue = (remaining != '0) && (occupancy < (CW+1)'(RDEPTH));
                if (rd_issue && (remaining == LW'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (remaining == LW'(1));
            if ((state == ST_IDLE) && bus.cmd_valid) begin
                addr      <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (wr_beat || rd_issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    dp_mem_burst_master_rd_fifo #(
        .DEPTH (RDEPTH),
        .DW    (DW)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.mem_rdata),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.wd_ready  = (state == ST_WRITE);
    assign bus.mem_wr_en = wr_beat;
    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = (state == ST_WRITE) ? bus.wd_data : '0;
    assign bus.rd_valid  = rd_avail;
    assign bus.rd_data   = rd_avail ? head_data : '0;
    assign bus.rd_last   = rd_avail && head_last;
    assign bus.busy      = is_active(state);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_dp_mem_burst_master.sv
// Randomised burst traffic against dp_mem_burst_master with a dp_mem responder;
// expectations come from a word-level memory image and burst rules.
module tb_dp_mem_burst_master;

    localparam int unsigned AW     = 10;
    localparam int unsigned DW     = 16;
    localparam int unsigned LW     = 11;
    localparam int unsigned RDEPTH = 2;
    localparam int unsigned DEPTH  = 1 << AW;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc   = 0;

    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] ref_mem   [DEPTH];

    always #5 clk = ~clk;

    dp_mem_burst_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

    dp_mem_burst_master #(
        .AW     (AW),
        .DW     (DW),
        .LW     (LW),
        .RDEPTH (RDEPTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // dp_mem responder: one-cycle read latency, write wins
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem_array[bus.mem_addr] <= bus.mem_wdata;
        end else if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem_array[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic pat(input int unsigned mode, input int unsigned k);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(3) != 0);
            default: return (k % 3 == 0);
        endcase
    endfunction

    task automatic check_idle(input string pfx);
        check({pfx, ".cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({pfx, ".wd_ready"},  32'(bus.wd_ready),  0);
        check({pfx, ".rd_valid"},  32'(bus.rd_valid),  0);
        check({pfx, ".rd_last"},   32'(bus.rd_last),   0);
        check({pfx, ".busy"},      32'(bus.busy),      0);
        check({pfx, ".done"},      32'(bus.done),      0);
        check({pfx, ".mem_rd_en"}, 32'(bus.mem_rd_en), 0);
        check({pfx, ".mem_wr_en"}, 32'(bus.mem_wr_en), 0);
        check({pfx, ".mem_addr"},  32'(bus.mem_addr),  0);
        check({pfx, ".mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({pfx, ".rd_data"},   32'(bus.rd_data),   0);
    endtask

    // Starts at posedge+1 and returns at posedge+1 with the DUT idle again.
    task automatic run_burst(input logic wr, input int unsigned addr, input int unsigned len,
                             input int unsigned mode, input bit timing);
        logic [DW-1:0] wq [$];
        int unsigned   beats = 0, issued = 0, pops = 0, k = 0, dones = 0, budget = 0;
        int            acc_cyc = -1, first_evt = -1, last_evt = -1, done_cyc = -1;
        bit            accepted = 0, finished = 0;
        int unsigned   limit = 20 * len + 50;

        for (int unsigned i = 0; i < len; i++) wq.push_back(DW'($urandom));
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        bus.wd_valid  = 1'b0;
        bus.rd_ready  = 1'b0;

        while (!finished && budget < limit) begin
            if (accepted) begin
                bus.wd_valid = wr && (beats < len) && pat(mode, k);
                bus.wd_data  = (beats < len) ? wq[beats] : DW'($urandom);
                bus.rd_ready = !wr && pat(mode, k);
            end
            @(negedge clk);
            if (bus.mem_rd_en || bus.mem_wr_en)
                check("mem_excl", 32'(bus.mem_rd_en && bus.mem_wr_en), 0);
            if (!accepted) begin
                if (bus.cmd_ready) begin
                    accepted = 1;
                    acc_cyc  = cyc;
                end
            end else begin
                if (cyc == acc_cyc + 1 && len != 0) begin
                    check("busy_after_acc", 32'(bus.busy), 1);
                    check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
                end
                if (len == 0) check("len0_rd_valid", 32'(bus.rd_valid), 0);
                if (wr) begin
                    check("wr_no_rd", 32'(bus.mem_rd_en), 0);
                    check("wr_no_rd_valid", 32'(bus.rd_valid), 0);
                    if (beats < len) check("wd_ready", 32'(bus.wd_ready), 1);
                    if (bus.wd_valid && bus.wd_ready) begin
                        check("wr_en", 32'(bus.mem_wr_en), 1);
                        check("wr_addr", 32'(bus.mem_addr), (addr + beats) % DEPTH);
                        check("wr_data", 32'(bus.mem_wdata), 32'(wq[beats]));
                        if (first_evt < 0) first_evt = cyc;
                        last_evt = cyc;
                        beats++;
                    end else if (bus.mem_wr_en) begin
                        check("wr_en_idle", 32'(bus.mem_wr_en), 0);
                    end
                end else begin
                    check("rd_no_wr", 32'(bus.mem_wr_en), 0);
                    if (bus.mem_rd_en) begin
                        check("rd_issue_cnt", 32'(issued < len), 1);
                        check("rd_addr", 32'(bus.mem_addr), (addr + issued) % DEPTH);
                        issued++;
                    end
                    if (bus.rd_valid && bus.rd_ready) begin
                        if (pops < len) begin
                            check("rd_data", 32'(bus.rd_data), 32'(ref_mem[(addr + pops) % DEPTH]));
                            check("rd_last", 32'(bus.rd_last), 32'(pops == len - 1));
                        end else begin
                            check("rd_extra", 32'(bus.rd_valid), 0);
                        end
                        if (first_evt < 0) first_evt = cyc;
                        last_evt = cyc;
                        pops++;
                    end
                    if (bus.mem_rd_en || bus.rd_valid)
                        check("rd_occupancy", 32'(int'(issued) - int'(pops) <= int'(RDEPTH)), 1);
                end
                if (bus.done) begin
                    dones++;
                    done_cyc = cyc;
                    check("busy_at_done", 32'(bus.busy), 0);
                end
                if (dones != 0 && cyc >= done_cyc + 2) finished = 1;
            end
            tick();
            budget++;
            k++;
            if (accepted) bus.cmd_valid = 1'b0;
        end

        bus.cmd_valid = 1'b0;
        bus.wd_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
        check("timeout", 32'(finished), 1);
        check("done_count", dones, 1);
        if (wr) check("beat_count", beats, len);
        else    check("pop_count", pops, len);
        check("done_timing", 32'(done_cyc), 32'(((len == 0) ? acc_cyc : last_evt) + 1));
        if (timing && len != 0) begin
            check("first_latency", 32'(first_evt - acc_cyc), wr ? 1 : 3);
            check("stream_span", 32'(last_evt - first_evt), len - 1);
        end
        if (wr) begin
            for (int unsigned i = 0; i < len; i++) ref_mem[(addr + i) % DEPTH] = wq[i];
        end
    endtask

    initial begin
        int unsigned pops;
        int unsigned budget;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '1;
        bus.rd_ready  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_idle("reset");
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_idle("post_reset");
        tick();

        // fill every word once so later reads have a defined image
        run_burst(1'b1, 0, DEPTH, 0, 1'b1);

        run_burst(1'b1, 5, 4, 0, 1'b1);
        run_burst(1'b0, 5, 4, 0, 1'b1);
        run_burst(1'b0, 5, 8, 2, 1'b0);
        run_burst(1'b1, 1022, 4, 0, 1'b1);
        run_burst(1'b0, 1022, 4, 0, 1'b1);
        run_burst(1'b1, 77, 0, 0, 1'b1);
        run_burst(1'b0, 77, 0, 0, 1'b1);

        // reset in the middle of a read burst
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = AW'(100);
        bus.cmd_len   = LW'(8);
        bus.rd_ready  = 1'b1;
        pops   = 0;
        budget = 0;
        while (pops < 2 && budget < 50) begin
            @(negedge clk);
            if (budget == 0) check("rst_pre_accept", 32'(bus.cmd_ready), 1);
            if (bus.rd_valid && bus.rd_ready) begin
                check("rst_pre_data", 32'(bus.rd_data), 32'(ref_mem[100 + pops]));
                pops++;
            end
            tick();
            budget++;
            bus.cmd_valid = 1'b0;
        end
        check("rst_pre_pops", pops, 2);
        reset        = 1'b0;
        bus.rd_ready = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        repeat (4) begin
            tick();
            @(negedge clk);
            check("mid_rst_done", 32'(bus.done), 0);
            check("mid_rst_rd_en", 32'(bus.mem_rd_en), 0);
            check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
        end
        tick();
        run_burst(1'b0, 100, 8, 0, 1'b1);

        for (int n = 0; n < 14; n++) begin
            int unsigned m;
            m = $urandom_range(2);
            run_burst(1'($urandom_range(1)), $urandom_range(DEPTH - 1),
                      $urandom_range(40), m, (m == 0));
        end

        run_burst(1'b1, 300, DEPTH, 1, 1'b0);
        run_burst(1'b0, 300, DEPTH, 2, 1'b0);
        run_burst(1'b0, 1000, 40, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
